// File: rtl/lock_reset_sequencer.sv
// Qualifies the PLL locked indication, then releases the downstream system reset.
// Any loss of lock in RUN re-asserts reset and is logged in a sticky flag and saturating counter.
module lock_reset_sequencer #(
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   locked_in,
    input  logic                   clear_lost,
    output logic                   sys_reset_out,
    output logic                   ready,
    output logic                   lost_lock,
    output logic [COUNT_WIDTH-1:0] loss_count
);

    localparam int unsigned MaxCycles = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

    localparam logic [CntWidth-1:0]    LockLast = CntWidth'(LOCK_CYCLES);
    localparam logic [CntWidth-1:0]    HoldLast = CntWidth'(HOLD_CYCLES);
    localparam logic [CntWidth-1:0]    CntOne   = CntWidth'(1);
    localparam logic [COUNT_WIDTH-1:0] LossOne  = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        StWaitLock,
        StQualify,
        StHold,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   sync1_q, locked_s;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;
    logic                   lost_lock_q, lost_lock_d;
    logic [COUNT_WIDTH-1:0] loss_count_q, loss_count_d;
    logic                   loss_event;

    // State register, two-flop synchroniser and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            locked_s     <= 1'b0;
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            lost_lock_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            sync1_q      <= locked_in;
            locked_s     <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            lost_lock_q  <= lost_lock_d;
            loss_count_q <= loss_count_d;
        end
    end

    // Next-state and qualification counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWaitLock: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = StQualify;
                    cnt_d   = CntOne;
                end
            end
            StQualify: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == LockLast) begin
                    state_d = StHold;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StHold: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = StWaitLock;
                end
            end
            default: begin
                state_d = StWaitLock;
                cnt_d   = '0;
            end
        endcase
    end

    assign loss_event = (state_q == StRun) && !locked_s;

    // Outputs are decoded from the current state so that reset drops one edge after RUN is
    // entered, yet re-asserts on the very edge that observes the loss.
    always_comb begin
        sys_reset_d  = 1'b1;
        ready_d      = 1'b0;
        lost_lock_d  = lost_lock_q;
        loss_count_d = loss_count_q;

        if ((state_q == StRun) && locked_s) begin
            sys_reset_d = 1'b0;
            ready_d     = 1'b1;
        end

        // A loss on the same edge as a clear wins: the clear applies first, then the count.
        if (loss_event) begin
            lost_lock_d = 1'b1;
            if (clear_lost) begin
                loss_count_d = LossOne;
            end else if (loss_count_q != '1) begin
                loss_count_d = loss_count_q + LossOne;
            end
        end else if (clear_lost) begin
            lost_lock_d  = 1'b0;
            loss_count_d = '0;
        end
    end

    assign sys_reset_out = sys_reset_q;
    assign ready         = ready_q;
    assign lost_lock     = lost_lock_q;
    assign loss_count    = loss_count_q;

endmodule
